control_state_register: RTL and testbench
=========================================

Name: control_state_register

Overview:
- State-holding stage directly downstream of the next-state decoder in the ARM microprogrammed control unit.
- Registers the decoder's 10-bit next-state proposal as the current state. Current state feeds back to the decoder and forward to the control-word encoder.
- Owns the memory handshake: asserts MOV, waits for MOC, times out on a hung bus.
- Captures the fetched instruction into IR and squashes instructions whose condition fails.

Parameters:
- STATE_W, 10, width of state and next_state.
- MOC_TIMEOUT, 16, wait cycles without MOC before abort; legal range 2..255.
- RESET_STATE, 0, state entered on reset and on abort.
- FETCH_STATE, 1, first fetch state; the target of a condition-fail squash.
- IR_LOAD_STATE, 3, memory-read state whose MOC completion loads IR.
- DECODE_STATE, 4, state in which the Cond result is applied.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- next_state  in  STATE_W  proposal from the next-state decoder.
- mem_req  in  1  control word for the current state requests a memory cycle.
- mem_write  in  1  control word: 1 = write, 0 = read; valid with mem_req.
- moc  in  1  memory operation complete.
- mem_rdata  in  32  memory data out.
- cond  in  1  condition-tester result for IR; sampled only in DECODE_STATE.
- state  out  STATE_W  current state.
- ir  out  32  instruction register.
- mov  out  1  memory operation valid.
- mem_rw  out  1  registered copy of mem_write while mov is high.
- squash  out  1  one-cycle pulse: condition failed, instruction discarded.
- abort  out  1  sticky bus-timeout flag.
- instr_count  out  16  count of retired (not squashed) decoded instructions.

Behaviour:
- Reset (reset_n low, asynchronous): state=RESET_STATE, ir=0, mov=0, mem_rw=0, squash=0, abort=0, instr_count=0, wait counter=0.
- Internal FSM, 3 states: RUN, MEMWAIT, ABORTED.
- RUN, mem_req=0:
  - state <= next_state on every edge.
  - Exception in DECODE_STATE: if cond=0, state <= FETCH_STATE and squash=1 for that cycle; otherwise state <= next_state and instr_count increments, wrapping at 0xFFFF to 0.
- RUN, mem_req=1: on the next edge, go to MEMWAIT.
  - mov <= 1, mem_rw <= mem_write, wait counter <= 1.
  - state is held.
  - Latency: mov rises 1 cycle after entry into a memory state.
- MEMWAIT, moc=1:
  - mov <= 0 and state <= next_state on the same edge; return to RUN.
  - If state==IR_LOAD_STATE and mem_rw=0, ir <= mem_rdata on that edge.
  - A memory state therefore lasts a minimum of 2 cycles.
- MEMWAIT, moc=0:
  - state is held; counter increments.
  - When the counter reaches MOC_TIMEOUT with moc still 0, on the next edge: abort <= 1, mov <= 0, state <= RESET_STATE, go to ABORTED.
- MOC and timeout on the same cycle: MOC wins; no abort.
- moc high outside MEMWAIT is ignored; it does not load IR or advance state.
- mem_write changing during MEMWAIT is ignored; mem_rw stays latched.
- ABORTED:
  - state is held at RESET_STATE; mov=0.
  - Exit requires reset_n low; abort clears only on reset.
- Reset asserted mid-MEMWAIT: mov drops immediately (asynchronous); no IR update.
- squash is a registered pulse, high exactly 1 cycle.
- Back-to-back memory states (next_state also has mem_req): a new MEMWAIT starts on the edge after returning to RUN. mov is low for at least 1 cycle between operations.

Decomposition:
- Shared package cu_pkg:
  - STATE_W;
  - named state constants (RESET_STATE, FETCH_STATE, IR_LOAD_STATE, DECODE_STATE);
  - the handshake-FSM enum {RUN, MEMWAIT, ABORTED}.
- One sub-module, mem_handshake_timer: MEMWAIT counter plus timeout compare, with start/moc inputs and a done/timeout output.
- State register, IR, squash and counters stay in the top.

Test Plan:
- Reset, then RUN: next_state=1, then 2, mem_req=0 → state follows 0→1→2 one cycle late; mov stays 0.
- Fetch read: state 3, mem_req=1, mem_write=0, moc high on the 3rd MEMWAIT cycle, mem_rdata=0xE2811001 → mov high 3 cycles, ir=0xE2811001, state=4 on the MOC edge.
- Condition fail: state=4, cond=0, next_state=5 → state=1, squash pulse 1 cycle, instr_count unchanged. Repeat with cond=1 → state=5, instr_count=1.
- Timeout: MOC_TIMEOUT=16, moc never asserted → abort=1 after the 16th wait cycle, mov=0, state=0, held there until reset_n pulses low.
- Boundary: moc rises on exactly the 16th wait cycle → no abort, normal advance. Separately, moc asserted in RUN → no state or IR change.
- Asynchronous reset mid-MEMWAIT with mov=1 → mov, state and abort drop immediately without a clock edge. After 0xFFFF retires, the next retire wraps instr_count to 0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the microprogrammed control unit: state width,
// named microstates and the memory-handshake FSM encoding.
package cu_pkg;

  localparam int STATE_W         = 10;
  localparam int MOC_TIMEOUT_DEF = 16;
  localparam int TIMER_W         = 8;

  localparam logic [STATE_W-1:0] RESET_STATE   = STATE_W'(0);
  localparam logic [STATE_W-1:0] FETCH_STATE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] IR_LOAD_STATE = STATE_W'(3);
  localparam logic [STATE_W-1:0] DECODE_STATE  = STATE_W'(4);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ABORTED = 2'd2
  } hs_state_t;

endpackage

// File: rtl/mem_handshake_timer.sv
// Counts cycles spent waiting for MOC and flags completion or a hung bus.
// The first wait cycle reads as 1; timeout fires on the cycle whose count
// equals TIMEOUT while moc is still low, so moc on that cycle still wins.
module mem_handshake_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic active,
  input  logic moc,
  output logic done,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  assign done    = active & moc;
  assign timeout = active & ~moc & (count == LIMIT);

  // wait counter: load 1 on start, step while waiting, clear otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (start) begin
      count <= CNT_W'(1);
    end else if (active && !moc && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/control_state_register.sv
// Current-state register of the microprogrammed control unit. Holds the
// decoder's proposal as the current state, runs the MOV/MOC memory
// handshake with a bus timeout, loads IR on the fetch read and squashes
// instructions whose condition fails in the decode state.
//
//   hs_state | meaning
//   ---------+------------------------------------------------------------
//   RUN      | state follows next_state; mem_req starts a memory cycle
//   MEMWAIT  | mov high, state held until moc or timeout
//   ABORTED  | bus timed out; state parked at RESET_STATE until reset
module control_state_register
  import cu_pkg::*;
#(
  parameter int unsigned MOC_TIMEOUT = MOC_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [STATE_W-1:0] next_state,
  input  logic               mem_req,
  input  logic               mem_write,
  input  logic               moc,
  input  logic [31:0]        mem_rdata,
  input  logic               cond,
  output logic [STATE_W-1:0] state,
  output logic [31:0]        ir,
  output logic               mov,
  output logic               mem_rw,
  output logic               squash,
  output logic               abort,
  output logic [15:0]        instr_count
);

  hs_state_t hs_state;
  logic      tmr_start;
  logic      tmr_active;
  logic      tmr_done;
  logic      tmr_timeout;
  logic      decode_slot;

  assign tmr_start   = (hs_state == RUN) && mem_req;
  assign tmr_active  = (hs_state == MEMWAIT);
  // a memory request in the decode state takes priority over the Cond check
  assign decode_slot = (hs_state == RUN) && !mem_req && (state == DECODE_STATE);

  mem_handshake_timer #(
    .TIMEOUT (MOC_TIMEOUT),
    .CNT_W   (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (tmr_start),
    .active  (tmr_active),
    .moc     (moc),
    .done    (tmr_done),
    .timeout (tmr_timeout)
  );

  // handshake FSM and its registered outputs mov, mem_rw, abort
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_state <= RUN;
      mov      <= 1'b0;
      mem_rw   <= 1'b0;
      abort    <= 1'b0;
    end else begin
      case (hs_state)
        RUN: begin
          if (mem_req) begin
            hs_state <= MEMWAIT;
            mov      <= 1'b1;
            mem_rw   <= mem_write;
          end
        end
        MEMWAIT: begin
          if (tmr_done) begin
            hs_state <= RUN;
            mov      <= 1'b0;
            mem_rw   <= 1'b0;
          end else if (tmr_timeout) begin
            hs_state <= ABORTED;
            mov      <= 1'b0;
            mem_rw   <= 1'b0;
            abort    <= 1'b1;
          end
        end
        ABORTED: begin
          mov    <= 1'b0;
          mem_rw <= 1'b0;
          abort  <= 1'b1;
        end
        default: begin
          hs_state <= ABORTED;
          mov      <= 1'b0;
          mem_rw   <= 1'b0;
          abort    <= 1'b1;
        end
      endcase
    end
  end

  // current state: follow the decoder, hold during memory waits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESET_STATE;
    end else begin
      case (hs_state)
        RUN: begin
          if (!mem_req) begin
            state <= (decode_slot && !cond) ? FETCH_STATE : next_state;
          end
        end
        MEMWAIT: begin
          if (tmr_done) begin
            state <= next_state;
          end else if (tmr_timeout) begin
            state <= RESET_STATE;
          end
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

  // instruction register: loaded only by a completed read in the IR load state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir <= '0;
    end else if (tmr_done && (state == IR_LOAD_STATE) && !mem_rw) begin
      ir <= mem_rdata;
    end
  end

  // one-cycle squash pulse when the decoded instruction fails its condition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      squash <= 1'b0;
    end else begin
      squash <= decode_slot && !cond;
    end
  end

  // retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= '0;
    end else if (decode_slot && cond) begin
      instr_count <= instr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_control_state_register.sv
// Bench for control_state_register: a fixed vector table for the main
// sequences, hand-written timeout/reset/wrap sequences, then random stimulus
// compared against a behavioural model of the handshake rules.
module tb_control_state_register;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  next_state = '0;
  logic        mem_req = 1'b0;
  logic        mem_write = 1'b0;
  logic        moc = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        cond = 1'b0;
  logic [9:0]  state;
  logic [31:0] ir;
  logic        mov;
  logic        mem_rw;
  logic        squash;
  logic        abort;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_pass   = 0;

  control_state_register #(.MOC_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .next_state  (next_state),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .moc         (moc),
    .mem_rdata   (mem_rdata),
    .cond        (cond),
    .state       (state),
    .ir          (ir),
    .mov         (mov),
    .mem_rw      (mem_rw),
    .squash      (squash),
    .abort       (abort),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // behavioural model: "busy" means a memory operation is outstanding,
  // waited counts the cycles of that operation seen so far
  logic [9:0]  m_state;
  logic [31:0] m_ir;
  logic        m_mov, m_rw, m_sq, m_abt, m_busy;
  logic [15:0] m_cnt;
  int          waited;

  task automatic model_reset();
    m_state = 10'd0; m_ir = '0; m_mov = 0; m_rw = 0; m_sq = 0;
    m_abt = 0; m_busy = 0; m_cnt = '0; waited = 0;
  endtask

  task automatic model_edge(input logic [9:0] ns, input logic rq, input logic wr,
                            input logic mc, input logic [31:0] rd, input logic cd);
    m_sq = 0;
    if (m_abt) begin
      m_state = 10'd0;
      m_mov = 0;
    end else if (m_busy) begin
      if (mc) begin
        if (m_state == 10'd3 && !m_rw) m_ir = rd;
        m_state = ns; m_busy = 0; m_mov = 0; m_rw = 0;
      end else if (waited == TMO) begin
        m_abt = 1; m_busy = 0; m_mov = 0; m_rw = 0; m_state = 10'd0;
      end else begin
        waited = waited + 1;
      end
    end else if (rq) begin
      m_busy = 1; m_mov = 1; m_rw = wr; waited = 1;
    end else if (m_state == 10'd4) begin
      if (cd) begin
        m_cnt = m_cnt + 16'd1;
        m_state = ns;
      end else begin
        m_state = 10'd1;
        m_sq = 1;
      end
    end else begin
      m_state = ns;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, " state"}, 32'(state), 32'(m_state));
    check({tag, " mov"}, 32'(mov), 32'(m_mov));
    check({tag, " squash"}, 32'(squash), 32'(m_sq));
    check({tag, " abort"}, 32'(abort), 32'(m_abt));
    check({tag, " ir"}, ir, m_ir);
    check({tag, " instr_count"}, 32'(instr_count), 32'(m_cnt));
    if (m_mov) check({tag, " mem_rw"}, 32'(mem_rw), 32'(m_rw));
  endtask

  task automatic step(input logic [9:0] ns, input logic rq, input logic wr, input logic mc,
                      input logic [31:0] rd, input logic cd, input bit chk, input string tag);
    next_state = ns; mem_req = rq; mem_write = wr; moc = mc; mem_rdata = rd; cond = cd;
    @(posedge clk);
    model_edge(ns, rq, wr, mc, rd, cd);
    #1;
    if (chk) check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    model_reset();
    #2;
    reset_n = 1;
  endtask

  // reset pulse placed mid-cycle, outputs checked before any clock edge
  task automatic async_reset_check(input string tag);
    #3;
    reset_n = 0;
    model_reset();
    #1;
    check({tag, " async mov"}, 32'(mov), 32'd0);
    check({tag, " async state"}, 32'(state), 32'd0);
    check({tag, " async abort"}, 32'(abort), 32'd0);
    @(negedge clk);
    #2;
    reset_n = 1;
  endtask

  typedef struct {
    logic [9:0]  ns;
    logic        rq, wr, mc;
    logic [31:0] rd;
    logic        cd;
    logic [9:0]  e_state;
    logic        e_mov, e_rw, e_sq;
    logic [31:0] e_ir;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [9:0] ns, input logic rq, input logic wr,
                              input logic mc, input logic [31:0] rd, input logic cd,
                              input logic [9:0] es, input logic em, input logic erw,
                              input logic esq, input logic [31:0] eir, input logic [15:0] ec);
    vec_t v;
    v.ns = ns; v.rq = rq; v.wr = wr; v.mc = mc; v.rd = rd; v.cd = cd;
    v.e_state = es; v.e_mov = em; v.e_rw = erw; v.e_sq = esq; v.e_ir = eir; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    //            ns  rq wr mc rdata          cd  state mov rw sq ir            cnt
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        1,  1,    0,  0, 0, 32'h0,        0));
    tbl.push_back(mk(2, 0, 0, 0, 32'h0,        1,  2,    0,  0, 0, 32'h0,        0));
    tbl.push_back(mk(3, 0, 0, 0, 32'h0,        1,  3,    0,  0, 0, 32'h0,        0));
    tbl.push_back(mk(9, 1, 0, 0, 32'h0,        1,  3,    1,  0, 0, 32'h0,        0));
    tbl.push_back(mk(4, 1, 1, 0, 32'h0,        1,  3,    1,  0, 0, 32'h0,        0));
    tbl.push_back(mk(4, 0, 1, 0, 32'h0,        1,  3,    1,  0, 0, 32'h0,        0));
    tbl.push_back(mk(4, 0, 0, 1, 32'hE2811001, 1,  4,    0,  0, 0, 32'hE2811001, 0));
    tbl.push_back(mk(5, 0, 0, 0, 32'h0,        0,  1,    0,  0, 1, 32'hE2811001, 0));
    tbl.push_back(mk(2, 0, 0, 0, 32'h0,        0,  2,    0,  0, 0, 32'hE2811001, 0));
    tbl.push_back(mk(3, 0, 0, 0, 32'h0,        1,  3,    0,  0, 0, 32'hE2811001, 0));
    tbl.push_back(mk(3, 1, 0, 0, 32'h0,        1,  3,    1,  0, 0, 32'hE2811001, 0));
    tbl.push_back(mk(4, 0, 0, 1, 32'h12345678, 1,  4,    0,  0, 0, 32'h12345678, 0));
    tbl.push_back(mk(5, 0, 0, 0, 32'h0,        1,  5,    0,  0, 0, 32'h12345678, 1));
    tbl.push_back(mk(5, 0, 0, 1, 32'hDEADBEEF, 1,  5,    0,  0, 0, 32'h12345678, 1));
    tbl.push_back(mk(3, 0, 0, 0, 32'h0,        1,  3,    0,  0, 0, 32'h12345678, 1));
    tbl.push_back(mk(3, 0, 0, 1, 32'hDEADBEEF, 1,  3,    0,  0, 0, 32'h12345678, 1));
    tbl.push_back(mk(3, 1, 1, 0, 32'h0,        1,  3,    1,  1, 0, 32'h12345678, 1));
    tbl.push_back(mk(4, 0, 0, 1, 32'hCAFEF00D, 1,  4,    0,  0, 0, 32'h12345678, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1,  0,    0,  0, 0, 32'h12345678, 2));
    tbl.push_back(mk(6, 1, 0, 0, 32'h0,        1,  0,    1,  0, 0, 32'h12345678, 2));
    tbl.push_back(mk(7, 1, 0, 1, 32'h0,        1,  7,    0,  0, 0, 32'h12345678, 2));
    tbl.push_back(mk(7, 1, 1, 0, 32'h0,        1,  7,    1,  1, 0, 32'h12345678, 2));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,        1,  0,    0,  0, 0, 32'h12345678, 2));

    model_reset();
    #12;
    reset_n = 1;
    check("reset state", 32'(state), 32'd0);
    check("reset ir", ir, 32'd0);
    check("reset mov", 32'(mov), 32'd0);
    check("reset mem_rw", 32'(mem_rw), 32'd0);
    check("reset squash", 32'(squash), 32'd0);
    check("reset abort", 32'(abort), 32'd0);
    check("reset instr_count", 32'(instr_count), 32'd0);

    // fixed vector table
    foreach (tbl[i]) begin
      step(tbl[i].ns, tbl[i].rq, tbl[i].wr, tbl[i].mc, tbl[i].rd, tbl[i].cd, 0, "");
      check($sformatf("vec%0d state", i), 32'(state), 32'(tbl[i].e_state));
      check($sformatf("vec%0d mov", i), 32'(mov), 32'(tbl[i].e_mov));
      check($sformatf("vec%0d squash", i), 32'(squash), 32'(tbl[i].e_sq));
      check($sformatf("vec%0d ir", i), ir, tbl[i].e_ir);
      check($sformatf("vec%0d instr_count", i), 32'(instr_count), 32'(tbl[i].e_cnt));
      check($sformatf("vec%0d abort", i), 32'(abort), 32'd0);
      if (tbl[i].e_mov) check($sformatf("vec%0d mem_rw", i), 32'(mem_rw), 32'(tbl[i].e_rw));
    end

    // moc arriving on exactly the last allowed wait cycle: no abort
    step(2, 0, 0, 0, 0, 1, 1, "bnd enter");
    step(9, 1, 0, 0, 0, 1, 1, "bnd start");
    for (int k = 1; k < TMO; k++) step(9, 0, 0, 0, 0, 1, 1, "bnd wait");
    step(5, 0, 0, 1, 32'h0BAD0BAD, 1, 1, "bnd moc");
    check("bnd no abort", 32'(abort), 32'd0);
    check("bnd advanced", 32'(state), 32'd5);

    // hung bus: abort after the last wait cycle, then parked until reset
    step(9, 1, 1, 0, 0, 1, 1, "tmo start");
    for (int k = 1; k < TMO; k++) step(9, 0, 0, 0, 0, 1, 1, "tmo wait");
    check("tmo mov before", 32'(mov), 32'd1);
    check("tmo abort before", 32'(abort), 32'd0);
    step(9, 0, 0, 0, 0, 1, 1, "tmo fire");
    check("tmo abort", 32'(abort), 32'd1);
    check("tmo state", 32'(state), 32'd0);
    for (int k = 0; k < 4; k++) step(7, 1, 0, 1, 32'h1, 1, 1, "tmo parked");
    async_reset_check("tmo");
    check_model("tmo after reset");

    // reset while a memory operation is outstanding
    step(3, 0, 0, 0, 0, 1, 1, "mid enter");
    step(3, 1, 0, 0, 0, 1, 1, "mid start");
    step(4, 0, 0, 0, 0, 1, 1, "mid wait");
    check("mid mov high", 32'(mov), 32'd1);
    async_reset_check("mid");
    step(0, 0, 0, 1, 32'hFFFFFFFF, 1, 1, "mid after");

    // instr_count wrap
    do_reset();
    step(4, 0, 0, 0, 0, 1, 1, "wrap enter");
    for (int k = 0; k < 70000 && m_cnt != 16'hFFFF; k++) step(4, 0, 0, 0, 0, 1, 0, "");
    check("wrap at max", 32'(instr_count), 32'hFFFF);
    step(4, 0, 0, 0, 0, 1, 1, "wrap");
    check("wrap to zero", 32'(instr_count), 32'd0);

    // random stimulus against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      step(10'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 1)), 1, "rand");
      if (m_abt && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
